// File: rtl/ls_queue_pkg.sv
// Shared types, constants and the stack-window predicate for the ls_queue
// load/store unit.
package ls_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [7:0]  byte_t;

    localparam logic  READ_SIGNAL  = 1'b0;
    localparam logic  WRITE_SIGNAL = 1'b1;
    localparam int    STK          = 12;
    localparam addr_t NULL_PTR     = 32'h0000_0000;

    typedef struct packed {
        logic       oper;
        addr_t      addr;
        logic [7:0] size;
        word_t      data;
    } ls_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_GAP
    } drain_state_t;

    // Caller passes addr[16:STK]; the window is where those bits are all ones.
    function automatic logic in_stack(input logic [16:STK] hi);
        return &hi;
    endfunction

endpackage

// File: rtl/ls_queue_stack_ram.sv
// On-chip stack scratchpad: 2^STK bytes, synchronous 1..4-byte write port and
// an asynchronous read port that returns bytes in increasing-address shift order.
module ls_stack_ram
    import ls_queue_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [STK-1:0]   wr_addr,
    input  logic [7:0]       wr_size,
    input  word_t            wr_data,
    input  logic [STK-1:0]   rd_addr,
    input  logic [7:0]       rd_size,
    output word_t            rd_data
);
    localparam int BYTES = 1 << STK;

    byte_t ram [BYTES];

    logic [STK-1:0] wa1, wa2, wa3;
    assign wa1 = wr_addr + STK'(1);
    assign wa2 = wr_addr + STK'(2);
    assign wa3 = wr_addr + STK'(3);

    always_ff @(posedge clk) begin
        if (we)                       ram[wr_addr] <= wr_data[7:0];
        if (we && (wr_size > 8'd1))   ram[wa1]     <= wr_data[15:8];
        if (we && (wr_size > 8'd2))   ram[wa2]     <= wr_data[23:16];
        if (we && (wr_size > 8'd3))   ram[wa3]     <= wr_data[31:24];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(rd_size))
                rd_data = {rd_data[23:0], ram[rd_addr + STK'(i)]};
        end
    end

endmodule

// File: rtl/ls_queue.sv
// Memory-side load/store queue: in-order FIFO drained byte-serially over an
// 8-bit memory port, plus a stack scratchpad. Optional macro: LS_IO_STALL_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a queued request and rdy
// ST_READ  | issuing load addresses and shifting in returned bytes
// ST_WRITE | issuing store bytes, one per cycle
// ST_GAP   | one quiet cycle on the port between entries
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        en_ls,
    input  logic        ls_oper,
    input  logic [31:0] ls_addr,
    input  logic [7:0]  ls_size,
    input  logic [31:0] ls_data,
    output logic [31:0] qsize,
    output logic        finish,
    output logic [31:0] ls_data_in,
    output logic [31:0] stk_data_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    localparam int SLOTS = DEPTH + 1;
    localparam int PW    = $clog2(SLOTS);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(SLOTS);
    localparam logic [PW-1:0] LAST_PTR = PW'(SLOTS - 1);

    ls_entry_t      fifo [SLOTS];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    ls_entry_t      head;
    logic           stk_hit, stk_we, push, pop, empty;

    drain_state_t   state, state_n;
    logic [7:0]     idx, idx_n;
    logic           cap_pend, cap_n;
    word_t          shift, shift_n, ld_n;
    addr_t          byte_addr;
    logic           io_hold;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign stk_hit = in_stack(ls_addr[16:STK]);
    assign stk_we  = en_ls && (ls_oper == WRITE_SIGNAL) && stk_hit;
    assign push    = en_ls && !stk_hit && (count != FULL_CNT);
    assign empty   = (count == '0);
    assign head    = fifo[rd_ptr];
    assign qsize   = 32'(count);

    ls_stack_ram u_stack (
        .clk     (clk),
        .we      (stk_we),
        .wr_addr (ls_addr[STK-1:0]),
        .wr_size (ls_size),
        .wr_data (ls_data),
        .rd_addr (ls_addr[STK-1:0]),
        .rd_size (ls_size),
        .rd_data (stk_data_in)
    );

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {ls_oper, ls_addr, ls_size, ls_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign byte_addr = head.addr + addr_t'(idx);

`ifdef LS_IO_STALL_EN
    assign io_hold = io_buffer_full && (byte_addr[17:16] == 2'b11);
`else
    logic unused_io;
    assign io_hold   = 1'b0;
    assign unused_io = io_buffer_full;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cap_pend   <= 1'b0;
            shift      <= '0;
            ls_data_in <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cap_pend   <= cap_n;
            shift      <= shift_n;
            ls_data_in <= ld_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cap_n    = 1'b0;
        shift_n  = shift;
        ld_n     = ls_data_in;
        finish   = 1'b0;
        pop      = 1'b0;
        mem_a    = NULL_PTR;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && rdy) begin
                    state_n = (head.oper == WRITE_SIGNAL) ? ST_WRITE : ST_READ;
                    idx_n   = '0;
                    shift_n = '0;
                end
            end
            ST_READ: begin
                // Returned bytes are captured even while frozen so an address
                // already on the port is never lost.
                if (cap_pend) shift_n = {shift[23:0], mem_din};
                if (idx == head.size) begin
                    if (cap_pend) begin
                        finish  = 1'b1;
                        ld_n    = {shift[23:0], mem_din};
                        pop     = 1'b1;
                        state_n = ST_GAP;
                    end
                end else begin
                    mem_a = byte_addr;
                    if (rdy) begin
                        idx_n = idx + 8'd1;
                        cap_n = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                mem_a    = byte_addr;
                mem_dout = byte_t'(head.data >> {idx[1:0], 3'b000});
                if (rdy && !io_hold) begin
                    mem_wr = 1'b1;
                    if (idx == head.size - 8'd1) begin
                        pop     = 1'b1;
                        state_n = ST_GAP;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end
            end
            ST_GAP: begin
                if (rdy) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ls_queue.sv
// Self-checking bench for ls_queue: byte memory model, write/load scoreboards
// and one task per scenario.
module tb_ls_queue;
    import ls_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, en_ls, ls_oper, finish, mem_wr, io_buffer_full;
    logic [31:0] ls_addr, ls_data, qsize, ls_data_in, stk_data_in, mem_a;
    logic [7:0]  ls_size, mem_dout;
    logic [7:0]  mem_din = 8'h00;

    int errors = 0;
    int checks = 0;
    int fin_count = 0;
    logic fin_d = 1'b0;

    logic [7:0] memm [logic [31:0]];
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t         exp_wr [$];
    logic [31:0] exp_ld [$];

    ls_queue #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .en_ls          (en_ls),
        .ls_oper        (ls_oper),
        .ls_addr        (ls_addr),
        .ls_size        (ls_size),
        .ls_data        (ls_data),
        .qsize          (qsize),
        .finish         (finish),
        .ls_data_in     (ls_data_in),
        .stk_data_in    (stk_data_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    // Memory returns the byte one cycle after its address.
    always @(posedge clk) mem_din <= memm.exists(mem_a) ? memm[mem_a] : 8'h00;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst && mem_wr) begin
            memm[mem_a] = mem_dout;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got a=%h d=%h, required no write", mem_a, mem_dout);
            end else begin
                e = exp_wr.pop_front();
                if (mem_a !== e.a || mem_dout !== e.d) begin
                    errors++;
                    $display("FAIL wr_order: got a=%h d=%h, required a=%h d=%h", mem_a, mem_dout, e.a, e.d);
                end
            end
        end
        if (fin_d) begin
            checks++;
            if (exp_ld.size() == 0) begin
                errors++;
                $display("FAIL ld_unexpected: got %h, required no load", ls_data_in);
            end else begin
                logic [31:0] w;
                w = exp_ld.pop_front();
                if (ls_data_in !== w) begin
                    errors++;
                    $display("FAIL ld_data: got %h, required %h", ls_data_in, w);
                end
            end
        end
        if (finish === 1'b1) fin_count++;
        fin_d = (finish === 1'b1);
    end

    function automatic void expect_req(input logic op, input logic [31:0] a,
                                       input logic [7:0] sz, input logic [31:0] d);
        logic [31:0] w;
        wr_t e;
        w = '0;
        for (int i = 0; i < int'(sz); i++) begin
            if (op == WRITE_SIGNAL) begin
                e.a = a + 32'(i);
                e.d = d[8*i +: 8];
                exp_wr.push_back(e);
            end else begin
                w = {w[23:0], memm.exists(a + 32'(i)) ? memm[a + 32'(i)] : 8'h00};
            end
        end
        if (op == READ_SIGNAL) exp_ld.push_back(w);
    endfunction

    task automatic drive(input logic op, input logic [31:0] a, input logic [7:0] sz, input logic [31:0] d);
        en_ls = 1'b1; ls_oper = op; ls_addr = a; ls_size = sz; ls_data = d;
    endtask

    // Returns just after the edge that samples the request.
    task automatic send(input logic op, input logic [31:0] a, input logic [7:0] sz,
                        input logic [31:0] d, input bit track);
        @(posedge clk); #1;
        drive(op, a, sz, d);
        if (track) expect_req(op, a, sz, d);
        @(posedge clk); #1;
        en_ls = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        while ((qsize != 0 || exp_wr.size() != 0 || exp_ld.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        ok = (n < budget);
    endtask

    task automatic test_reset();
        int f0;
        bit hit = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (qsize !== 32'd0) begin errors++; $display("FAIL reset_qsize: got %0d, required 0", qsize); end
        checks++;
        if (finish !== 1'b0 || mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0 || ls_data_in !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got fin=%b wr=%b a=%h dout=%h ld=%h, required all 0",
                     finish, mem_wr, mem_a, mem_dout, ls_data_in);
        end
        send(READ_SIGNAL, 32'h100, 8'd4, 32'd0, 1'b0);
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (mem_a === 32'h101) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_read_start: got no address 101, required it within 20 cycles"); end
        f0 = fin_count;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (qsize !== 32'd0 || finish !== 1'b0 || mem_wr !== 1'b0 || mem_a !== 32'd0 || ls_data_in !== 32'd0) begin
            errors++;
            $display("FAIL rst_midread: got q=%0d fin=%b wr=%b a=%h ld=%h, required all 0",
                     qsize, finish, mem_wr, mem_a, ls_data_in);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (fin_count != f0) begin errors++; $display("FAIL rst_finish: got %0d pulses, required 0", fin_count - f0); end
        checks++;
        if (qsize !== 32'd0 || ls_data_in !== 32'd0) begin
            errors++;
            $display("FAIL rst_after: got q=%0d ld=%h, required 0 and 0", qsize, ls_data_in);
        end
    endtask

    task automatic test_load();
        logic [31:0] la [40];
        logic        lf [40];
        int c0 = -1;
        int nf = 0;
        send(READ_SIGNAL, 32'h100, 8'd4, 32'd0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            la[k] = mem_a;
            lf[k] = finish;
        end
        for (int k = 0; k < 32; k++) if (c0 < 0 && la[k] === 32'h100) c0 = k;
        checks++;
        if (c0 < 0) begin
            errors++;
            $display("FAIL load_start: got no address 100, required one");
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (la[c0+i] !== 32'h100 + 32'(i)) begin
                    errors++;
                    $display("FAIL load_addr%0d: got %h, required %h", i, la[c0+i], 32'h100 + 32'(i));
                end
            end
            checks++;
            if (lf[c0+4] !== 1'b1) begin errors++; $display("FAIL load_latency: got finish=%b at C+4, required 1", lf[c0+4]); end
            for (int k = 0; k < 40; k++) if (lf[k] === 1'b1) nf++;
            checks++;
            if (nf != 1) begin errors++; $display("FAIL load_pulses: got %0d, required 1", nf); end
        end
        checks++;
        if (ls_data_in !== 32'h11223344) begin errors++; $display("FAIL load_result: got %h, required 11223344", ls_data_in); end
    endtask

    task automatic test_store();
        bit ok;
        send(WRITE_SIGNAL, 32'h200, 8'd2, 32'h0000BEEF, 1'b1);
        checks++;
        if (qsize !== 32'd1) begin errors++; $display("FAIL store_q1: got %0d, required 1", qsize); end
        wait_drain(40, ok);
        checks++;
        if (!ok || qsize !== 32'd0) begin errors++; $display("FAIL store_drain: got q=%0d ok=%b, required 0 and 1", qsize, ok); end
        checks++;
        if (memm[32'h200] !== 8'hEF || memm[32'h201] !== 8'hBE) begin
            errors++;
            $display("FAIL store_mem: got %h %h, required ef be", memm[32'h200], memm[32'h201]);
        end
    endtask

    task automatic test_stack();
        int busy = 0;
        @(posedge clk); #1;
        drive(WRITE_SIGNAL, 32'h1FFF0, 8'd4, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(READ_SIGNAL, 32'h1FFF0, 8'd4, 32'd0);
        #1;
        checks++;
        if (stk_data_in !== 32'hEFBEADDE) begin errors++; $display("FAIL stk_lw: got %h, required efbeadde", stk_data_in); end
        ls_addr = 32'h1FFF1; ls_size = 8'd1; #1;
        checks++;
        if (stk_data_in !== 32'h000000BE) begin errors++; $display("FAIL stk_lb: got %h, required 000000be", stk_data_in); end
        ls_addr = 32'h1FFF2; ls_size = 8'd2; #1;
        checks++;
        if (stk_data_in !== 32'h0000ADDE) begin errors++; $display("FAIL stk_lh: got %h, required 0000adde", stk_data_in); end
        @(posedge clk); #1;
        en_ls = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_a !== 32'd0 || mem_wr !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0 || qsize !== 32'd0) begin
            errors++;
            $display("FAIL stk_noqueue: got busy=%0d q=%0d, required 0 and 0", busy, qsize);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        bit ok;
        f0 = fin_count;
        @(posedge clk); #1;
        drive(READ_SIGNAL, 32'h102, 8'd1, 32'd0);          expect_req(READ_SIGNAL, 32'h102, 8'd1, 32'd0);
        @(posedge clk); #1;
        drive(READ_SIGNAL, 32'h101, 8'd2, 32'd0);          expect_req(READ_SIGNAL, 32'h101, 8'd2, 32'd0);
        @(posedge clk); #1;
        drive(WRITE_SIGNAL, 32'h600, 8'd1, 32'h0000005A);  expect_req(WRITE_SIGNAL, 32'h600, 8'd1, 32'h5A);
        @(posedge clk); #1;
        drive(READ_SIGNAL, 32'h100, 8'd4, 32'd0);          expect_req(READ_SIGNAL, 32'h100, 8'd4, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (qsize > 32'd4 || qsize < 32'd3) begin errors++; $display("FAIL b2b_q: got %0d, required 3 or 4", qsize); end
        en_ls = 1'b0;
        wait_drain(80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got q=%0d, required 0 within budget", qsize); end
        checks++;
        if (fin_count - f0 != 3) begin errors++; $display("FAIL b2b_pulses: got %0d, required 3", fin_count - f0); end
        checks++;
        if (ls_data_in !== 32'h11223344) begin errors++; $display("FAIL b2b_hold: got %h, required 11223344", ls_data_in); end
    endtask

    task automatic test_rdy_freeze();
        int f0;
        bit hit = 0;
        bit ok;
        f0 = fin_count;
        send(READ_SIGNAL, 32'h100, 8'd4, 32'd0, 1'b1);
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (mem_a === 32'h101) hit = 1;
        end
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
        wait_drain(40, ok);
        checks++;
        if (!hit || !ok) begin errors++; $display("FAIL freeze_run: got hit=%b ok=%b, required 1 and 1", hit, ok); end
        checks++;
        if (fin_count - f0 != 1 || ls_data_in !== 32'h11223344) begin
            errors++;
            $display("FAIL freeze_result: got pulses=%0d ld=%h, required 1 and 11223344", fin_count - f0, ls_data_in);
        end
    endtask

    task automatic test_full();
        bit ok;
        rdy = 1'b0;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            if (k > 0) begin
                checks++;
                if (qsize !== 32'(k)) begin errors++; $display("FAIL full_fill%0d: got %0d, required %0d", k, qsize, k); end
            end
            drive(WRITE_SIGNAL, 32'h400 + 32'(k), 8'd1, 32'(k + 1));
            expect_req(WRITE_SIGNAL, 32'h400 + 32'(k), 8'd1, 32'(k + 1));
        end
        @(posedge clk); #1;
        checks++;
        if (qsize !== 32'd17) begin errors++; $display("FAIL full_17: got %0d, required 17", qsize); end
        drive(WRITE_SIGNAL, 32'h500, 8'd1, 32'h99);
        @(posedge clk); #1;
        en_ls = 1'b0;
        checks++;
        if (qsize !== 32'd17) begin errors++; $display("FAIL full_drop: got %0d, required 17", qsize); end
        rdy = 1'b1;
        wait_drain(120, ok);
        checks++;
        if (!ok || qsize !== 32'd0) begin errors++; $display("FAIL full_drain: got q=%0d ok=%b, required 0 and 1", qsize, ok); end
    endtask

    task automatic test_io_stall();
        int nwr = 0;
        bit ok;
        io_buffer_full = 1'b1;
        send(WRITE_SIGNAL, 32'h30000, 8'd1, 32'h000000A5, 1'b1);
        repeat (5) begin
            @(negedge clk);
            if (mem_wr === 1'b1) nwr++;
        end
        io_buffer_full = 1'b0;
`ifdef LS_IO_STALL_EN
        checks++;
        if (nwr != 0) begin errors++; $display("FAIL io_hold: got %0d writes, required 0", nwr); end
        repeat (5) begin
            @(negedge clk);
            if (mem_wr === 1'b1) nwr++;
        end
        checks++;
        if (nwr != 1) begin errors++; $display("FAIL io_release: got %0d writes, required 1", nwr); end
`else
        checks++;
        if (nwr != 1) begin errors++; $display("FAIL io_ignored: got %0d writes, required 1", nwr); end
`endif
        wait_drain(40, ok);
        checks++;
        if (!ok || memm[32'h30000] !== 8'hA5) begin
            errors++;
            $display("FAIL io_data: got ok=%b mem=%h, required 1 and a5", ok, memm[32'h30000]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; en_ls = 1'b0; ls_oper = READ_SIGNAL;
        ls_addr = '0; ls_size = '0; ls_data = '0; io_buffer_full = 1'b0;
        memm[32'h100] = 8'h11;
        memm[32'h101] = 8'h22;
        memm[32'h102] = 8'h33;
        memm[32'h103] = 8'h44;
        test_reset();
        test_load();
        test_store();
        test_stack();
        test_back_to_back();
        test_rdy_freeze();
        test_full();
        test_io_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ls_queue.md
# ls_queue

Memory-side load/store unit that consumes requests from the load/store execute stage and serves them through the 8-bit external memory port. Requests outside the stack window go into an in-order FIFO. A drain engine serialises each request into single-byte reads or writes. Addresses inside the stack window (`addr[16:STK]` all ones) are served by an on-chip scratchpad without queuing. The block returns load results, a completion pulse and the queue occupancy to the execute stage.

## Interface
- `DEPTH`, 16, upstream admission threshold; storage holds `DEPTH+1` entries.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  when low, the drain engine freezes.
- `en_ls`  in  1  request valid, single-cycle.
- `ls_oper`  in  1  `READ_SIGNAL` / `WRITE_SIGNAL`.
- `ls_addr`  in  32  byte address.
- `ls_size`  in  8  byte count: 1, 2 or 4.
- `ls_data`  in  32  store data; byte i goes to `addr+i` as `ls_data[8i+7:8i]`.
- `qsize`  out  32  occupied entries, including the entry in service.
- `finish`  out  1  one-cycle pulse marking a completed memory load.
- `ls_data_in`  out  32  load result, byte-shifted.
- `stk_data_in`  out  32  combinational scratchpad read at `ls_addr`/`ls_size`, byte-shifted.
- `mem_din`  in  8  memory read byte, valid one cycle after its address.
- `mem_dout`  out  8  memory write byte.
- `mem_a`  out  32  memory address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  I/O sink backpressure (see Configuration).

## Operation
- Byte-shift format for an N-byte load: `result = {result[23:0], byte}`, with bytes taken in increasing address order. For LW, `[31:24]` = byte at `addr`; for LB, `[7:0]` = byte at `addr`.
- Stack request, `en_ls` high with an address in the window:
  - Store: writes `ls_size` bytes into the scratchpad at the clock edge.
  - Load: no action; the upstream stage samples `stk_data_in` directly.
  - Never enqueued; `qsize` unchanged.
- Other requests: pushed at the tail with entry `{oper, addr, size, data}`. A push while `DEPTH+1` entries are occupied is dropped; this is an upstream protocol error.
- Drain FSM:
  - IDLE: if not empty and `rdy`, go to READ or WRITE according to the head entry; byte index `i=0`.
  - READ:
    - Drives `mem_a=addr+i`, `mem_wr=0`, for i=0..N-1 on consecutive cycles.
    - Shifts `mem_din` in one cycle after each address.
    - After the last capture: `ls_data_in` updated, `finish` pulses, pop, go to GAP.
  - WRITE: drives `mem_a=addr+i`, `mem_dout=data byte i`, `mem_wr=1`, for N cycles; then pop, go to GAP.
  - GAP: one cycle with `mem_a=0` and `mem_wr=0`; then IDLE.
- `rdy` low freezes state and byte index and forces `mem_wr=0`. A READ capture whose address went out before the freeze still completes.
- Simultaneous push and pop: `qsize` unchanged. Pointers wrap modulo `DEPTH+1`.
- `ls_data_in` holds its value until the next load completes.

## Timing
- Reset (asynchronous) clears the FIFO, state to IDLE, and all outputs to 0 (`ls_data_in`, `finish`, `qsize`, `mem_*`). An in-flight request is discarded.
- `qsize` is registered and reflects pushes and pops at the current edge.
- Upstream decides on the previous cycle's `qsize`, so one in-flight request can arrive after `qsize=DEPTH` is visible. The extra slot absorbs it.
- Load of N bytes, first address in cycle C: `finish` is high in cycle C+N.
- Store of N bytes: occupies the port for N cycles; pop at the end of cycle C+N-1.
- Each entry is followed by one GAP cycle.
- Head enters service no earlier than the cycle after its push.

## Configuration
- `LS_IO_STALL_EN` defined: a WRITE byte to an address with `addr[17:16]==2'b11` holds (`mem_wr=0`, no advance) while `io_buffer_full` is high.
- Not defined: `io_buffer_full` is ignored.

## Structure
- Shared package: `word_t`, `addr_t`, `byte_t`, `READ_SIGNAL`, `WRITE_SIGNAL`, `STK`, `NULL_PTR`, and the stack-window predicate.
- Sub-module `ls_stack_ram`: 2^`STK`-byte scratchpad with a 4-byte-wide synchronous write port and an asynchronous shifted read port.

## Test plan
- Reset during a READ of an LW → all outputs 0, `qsize=0`, no `finish` pulse.
- LW at 0x100, memory bytes 11,22,33,44 → `mem_a` 0x100..0x103 on consecutive cycles; `finish` 4 cycles after the first address; `ls_data_in=0x11223344`.
- SH at 0x200 with data 0xBEEF → writes EF@0x200 and BE@0x201 with `mem_wr=1`; `qsize` goes 1→0.
- Stack SW at 0x1FFF0 with data 0xDEADBEEF, then LW at the same address → `stk_data_in=0xEFBEADDE` combinationally; no memory traffic; `qsize` stays 0.
- 17 back-to-back SBs with `rdy=0` → `qsize=17`; an 18th is dropped; after `rdy=1`, 17 writes drain in order.
- `LS_IO_STALL_EN` defined: SB to 0x30000 with `io_buffer_full=1` for 5 cycles → `mem_wr` stays 0 until the flag drops, then one write.
